// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the MEM stage and the FFT engine.
// Define DMEM_ARB_STARVE_EN to add the FFT starvation counter and forced FFT grant.
module dmem_arbiter #(
    parameter int DATA_W        = 32,
    parameter int ADDR_W        = 4,
    parameter int FFT_BURST_MAX = 8,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              stall_pipe,

    input  logic              fft_req,
    input  logic              fft_we,
    input  logic [ADDR_W-1:0] fft_addr,
    input  logic [DATA_W-1:0] fft_wdata,
    input  logic              fft_last,
    output logic              fft_gnt,
    output logic              fft_rvalid,
    output logic [DATA_W-1:0] fft_rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic       ST_ARB       = 1'b0;
    localparam logic       ST_FFT_BURST = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_FFT  = 2'd2;

    localparam logic [3:0] BURST_MAX = 4'(FFT_BURST_MAX);

    // Both counters are 4 bits wide, so the limits must fit in 1..15.
    generate
        if (FFT_BURST_MAX < 1 || FFT_BURST_MAX > 15 ||
            STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : gBadParam
            $error("dmem_arbiter: FFT_BURST_MAX and STARVE_LIMIT must be in 1..15");
        end
    endgenerate

    logic       state_q, state_d;
    logic [3:0] beatCnt_q, beatCnt_d;
    logic [1:0] rdOwner_q, rdOwner_d;

    logic cpuGrant;
    logic fftGrant;
    logic starved;

`ifdef DMEM_ARB_STARVE_EN
    logic [3:0] starveCnt_q, starveCnt_d;
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    assign starved = (starveCnt_q == STARVE_MAX);

    always_comb begin
        starveCnt_d = starveCnt_q;
        if (fftGrant) begin
            starveCnt_d = 4'd0;
        end else if (fft_req && (starveCnt_q != STARVE_MAX)) begin
            starveCnt_d = starveCnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            starveCnt_q <= 4'd0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end
`else
    assign starved = 1'b0;
`endif

    // Grants are suppressed while reset is high so every output reads 0 during reset.
    always_comb begin
        cpuGrant  = 1'b0;
        fftGrant  = 1'b0;
        state_d   = state_q;
        beatCnt_d = beatCnt_q;
        if (!reset) begin
            if (state_q == ST_ARB) begin
                if (fft_req && (!cpu_req || starved)) begin
                    fftGrant  = 1'b1;
                    beatCnt_d = 4'd1;
                    if (!fft_last && (BURST_MAX != 4'd1)) begin
                        state_d = ST_FFT_BURST;
                    end
                end else if (cpu_req) begin
                    cpuGrant = 1'b1;
                end
            end else begin
                // A dropped fft_req mid-burst aborts; the CPU still waits out this cycle.
                if (fft_req) begin
                    fftGrant  = 1'b1;
                    beatCnt_d = beatCnt_q + 4'd1;
                    if (fft_last || ((beatCnt_q + 4'd1) == BURST_MAX)) begin
                        state_d = ST_ARB;
                    end
                end else begin
                    state_d = ST_ARB;
                end
            end
        end
    end

    always_comb begin
        rdOwner_d = OWN_NONE;
        if (cpuGrant && !cpu_we) begin
            rdOwner_d = OWN_CPU;
        end else if (fftGrant && !fft_we) begin
            rdOwner_d = OWN_FFT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_ARB;
            beatCnt_q <= 4'd0;
            rdOwner_q <= OWN_NONE;
        end else begin
            state_q   <= state_d;
            beatCnt_q <= beatCnt_d;
            rdOwner_q <= rdOwner_d;
        end
    end

    assign cpu_gnt    = cpuGrant;
    assign fft_gnt    = fftGrant;
    assign stall_pipe = cpu_req & ~cpuGrant & ~reset;

    assign mem_en    = cpuGrant | fftGrant;
    assign mem_we    = (cpuGrant & cpu_we) | (fftGrant & fft_we);
    assign mem_addr  = cpuGrant ? cpu_addr  : (fftGrant ? fft_addr  : '0);
    assign mem_wdata = cpuGrant ? cpu_wdata : (fftGrant ? fft_wdata : '0);

    assign cpu_rvalid = (rdOwner_q == OWN_CPU) & ~reset;
    assign fft_rvalid = (rdOwner_q == OWN_FFT) & ~reset;
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign fft_rdata  = fft_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized traffic checked against a transaction-level model.
// Honors DMEM_ARB_STARVE_EN the same way the design does.
module tb_dmem_arbiter;

    localparam int DATA_W       = 32;
    localparam int ADDR_W       = 4;
    localparam int BURST_MAX    = 8;
    localparam int STARVE_LIMIT = 4;
`ifdef DMEM_ARB_STARVE_EN
    localparam bit STARVE_EN = 1'b1;
`else
    localparam bit STARVE_EN = 1'b0;
`endif

    typedef struct packed {
        logic              cpuGnt;
        logic              cpuRv;
        logic [DATA_W-1:0] cpuRdata;
        logic              stall;
        logic              fftGnt;
        logic              fftRv;
        logic [DATA_W-1:0] fftRdata;
        logic              memEn;
        logic              memWe;
        logic [ADDR_W-1:0] memAddr;
        logic [DATA_W-1:0] memWdata;
    } portView_t;

    logic clk = 1'b0;
    logic reset;
    logic cpu_req, cpu_we, cpu_gnt, cpu_rvalid, stall_pipe;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic fft_req, fft_we, fft_last, fft_gnt, fft_rvalid;
    logic [ADDR_W-1:0] fft_addr;
    logic [DATA_W-1:0] fft_wdata, fft_rdata;
    logic mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W),
        .FFT_BURST_MAX(BURST_MAX), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata), .stall_pipe(stall_pipe),
        .fft_req(fft_req), .fft_we(fft_we), .fft_addr(fft_addr), .fft_wdata(fft_wdata),
        .fft_last(fft_last), .fft_gnt(fft_gnt), .fft_rvalid(fft_rvalid), .fft_rdata(fft_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Synchronous single-port memory hanging off the arbiter's memory port.
    bit [DATA_W-1:0] tbMem [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) tbMem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tbMem[mem_addr];
        end
    end

    // Reference model: who owns the port, how long the FFT has waited, and who gets read data next.
    bit              mHolding;
    int              mBeats;
    int              mWait;
    int              mOwner;
    bit [DATA_W-1:0] mMem [16];
    bit [DATA_W-1:0] mPend;

    function automatic portView_t modelEval();
        portView_t e;
        e = '0;
        if (reset !== 1'b1) begin
            if (mHolding) begin
                e.fftGnt = fft_req;
            end else begin
                e.fftGnt = fft_req && (!cpu_req || (STARVE_EN && mWait >= STARVE_LIMIT));
                e.cpuGnt = cpu_req && !e.fftGnt;
            end
            e.stall    = cpu_req && !e.cpuGnt;
            e.cpuRv    = (mOwner == 1);
            e.fftRv    = (mOwner == 2);
            e.cpuRdata = e.cpuRv ? mPend : '0;
            e.fftRdata = e.fftRv ? mPend : '0;
            if (e.cpuGnt) begin
                e.memEn = 1'b1; e.memWe = cpu_we; e.memAddr = cpu_addr; e.memWdata = cpu_wdata;
            end
            if (e.fftGnt) begin
                e.memEn = 1'b1; e.memWe = fft_we; e.memAddr = fft_addr; e.memWdata = fft_wdata;
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin : modelCommit
        portView_t e;
        int nb;
        e = modelEval();
        if (reset) begin
            mHolding <= 1'b0;
            mBeats   <= 0;
            mWait    <= 0;
            mOwner   <= 0;
        end else begin
            if (e.cpuGnt && cpu_we) mMem[cpu_addr] <= cpu_wdata;
            if (e.fftGnt && fft_we) mMem[fft_addr] <= fft_wdata;
            if (e.cpuGnt && !cpu_we) begin
                mOwner <= 1; mPend <= mMem[cpu_addr];
            end else if (e.fftGnt && !fft_we) begin
                mOwner <= 2; mPend <= mMem[fft_addr];
            end else begin
                mOwner <= 0;
            end
            if (e.fftGnt) mWait <= 0;
            else if (fft_req && mWait < STARVE_LIMIT) mWait <= mWait + 1;
            if (e.fftGnt) begin
                nb = mHolding ? mBeats + 1 : 1;
                mBeats   <= nb;
                mHolding <= !fft_last && (nb < BURST_MAX);
            end else begin
                mHolding <= 1'b0;
            end
        end
    end

    function automatic portView_t observe();
        portView_t o;
        o.cpuGnt = cpu_gnt; o.cpuRv = cpu_rvalid; o.cpuRdata = cpu_rdata; o.stall = stall_pipe;
        o.fftGnt = fft_gnt; o.fftRv = fft_rvalid; o.fftRdata = fft_rdata;
        o.memEn = mem_en; o.memWe = mem_we; o.memAddr = mem_addr; o.memWdata = mem_wdata;
        return o;
    endfunction

    task automatic applyStimulus(input logic cr, input logic cw, input logic [3:0] ca, input logic [31:0] cd,
                                 input logic fr, input logic fw, input logic [3:0] fa, input logic [31:0] fd,
                                 input logic fl);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        fft_req = fr; fft_we = fw; fft_addr = fa; fft_wdata = fd; fft_last = fl;
    endtask

    task automatic toSample();
        @(negedge clk);
    endtask

    task automatic toDrive();
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        toSample();
        toDrive();
    endtask

    task automatic test_reset();
        portView_t o;
        reset = 1'b1;
        applyStimulus(1, 1, 4'd1, 32'h11, 1, 1, 4'd2, 32'h22, 0);
        toSample();
        o = observe();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h want 0", o);
        end
        toDrive();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        toSample();
        o = observe();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("[TB] FAIL post_reset_outputs: got %h want 0", o);
        end
        toDrive();
    endtask

    task automatic test_cpu_store_load();
        applyStimulus(1, 1, 4'd3, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        toSample();
        checks++;
        if ({cpu_gnt, stall_pipe, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 1'b1, 4'd3, 32'hDEADBEEF}) begin
            errors++;
            $display("[TB] FAIL cpu_store: gnt=%b stall=%b we=%b addr=%h wdata=%h want 1 0 1 3 deadbeef",
                     cpu_gnt, stall_pipe, mem_we, mem_addr, mem_wdata);
        end
        toDrive();
        applyStimulus(1, 0, 4'd3, 0, 0, 0, 0, 0, 0);
        toSample();
        checks++;
        if ({cpu_gnt, stall_pipe, mem_we} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL cpu_load_gnt: gnt=%b stall=%b we=%b want 1 0 0", cpu_gnt, stall_pipe, mem_we);
        end
        toDrive();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        toSample();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF || fft_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL cpu_load_data: rvalid=%b rdata=%h fft_rvalid=%b want 1 deadbeef 0",
                     cpu_rvalid, cpu_rdata, fft_rvalid);
        end
        toDrive();
    endtask

    task automatic test_fft_burst();
        for (int b = 0; b < 4; b++) begin
            applyStimulus(b >= 1, 1, 4'd9, 32'h12345678, 1, 1, 4'(b), 32'hF0000000 | 32'(b), b == 3);
            toSample();
            checks++;
            if (fft_gnt !== 1'b1 || cpu_gnt !== 1'b0 || stall_pipe !== (b >= 1)) begin
                errors++;
                $display("[TB] FAIL burst_beat%0d: fft_gnt=%b cpu_gnt=%b stall=%b want 1 0 %b",
                         b + 1, fft_gnt, cpu_gnt, stall_pipe, b >= 1);
            end
            toDrive();
        end
        applyStimulus(1, 1, 4'd9, 32'h12345678, 0, 0, 0, 0, 0);
        toSample();
        checks++;
        if (cpu_gnt !== 1'b1 || fft_gnt !== 1'b0 || stall_pipe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL burst_cpu_after: cpu_gnt=%b fft_gnt=%b stall=%b want 1 0 0",
                     cpu_gnt, fft_gnt, stall_pipe);
        end
        toDrive();
        idleCycle();
    endtask

    task automatic test_burst_max();
        for (int c = 1; c <= 13; c++) begin
            int beat;
            beat = (c <= 9) ? c : c - 1;
            applyStimulus(c >= 2 && c <= 9, 1, 4'd14, 32'hC0FFEE00,
                          1, 1, 4'(beat), 32'hB0000000 | 32'(beat), beat == 12);
            toSample();
            checks++;
            if (fft_gnt !== (c != 9) || cpu_gnt !== (c == 9) || stall_pipe !== (c >= 2 && c <= 8)) begin
                errors++;
                $display("[TB] FAIL burst_max_cycle%0d: fft_gnt=%b cpu_gnt=%b stall=%b want %b %b %b",
                         c, fft_gnt, cpu_gnt, stall_pipe, c != 9, c == 9, c >= 2 && c <= 8);
            end
            toDrive();
        end
        idleCycle();
    endtask

    task automatic test_starvation();
        for (int c = 1; c <= 6; c++) begin
            bit wantFft;
            wantFft = STARVE_EN && (c == 5);
            applyStimulus(1, 1, 4'd10, 32'(c), 1, 1, 4'd12, 32'hABCD, 1);
            toSample();
            checks++;
            if (fft_gnt !== wantFft || cpu_gnt !== !wantFft) begin
                errors++;
                $display("[TB] FAIL starve_cycle%0d: fft_gnt=%b cpu_gnt=%b want %b %b",
                         c, fft_gnt, cpu_gnt, wantFft, !wantFft);
            end
            toDrive();
        end
        idleCycle();
    endtask

    task automatic test_simultaneous_read();
        applyStimulus(1, 1, 4'd5, 32'h5555AAAA, 0, 0, 0, 0, 0);
        toDrive();
        applyStimulus(1, 1, 4'd6, 32'h6666BBBB, 0, 0, 0, 0, 0);
        toDrive();
        applyStimulus(1, 0, 4'd5, 0, 1, 0, 4'd6, 0, 1);
        toSample();
        checks++;
        if (cpu_gnt !== 1'b1 || fft_gnt !== 1'b0) begin
            errors++;
            $display("[TB] FAIL simul_gnt: cpu_gnt=%b fft_gnt=%b want 1 0", cpu_gnt, fft_gnt);
        end
        toDrive();
        applyStimulus(0, 0, 0, 0, 1, 0, 4'd6, 0, 1);
        toSample();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h5555AAAA || fft_rvalid !== 1'b0 || fft_gnt !== 1'b1) begin
            errors++;
            $display("[TB] FAIL simul_cpu_data: rvalid=%b rdata=%h fft_rvalid=%b fft_gnt=%b want 1 5555aaaa 0 1",
                     cpu_rvalid, cpu_rdata, fft_rvalid, fft_gnt);
        end
        toDrive();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        toSample();
        checks++;
        if (fft_rvalid !== 1'b1 || fft_rdata !== 32'h6666BBBB || cpu_rvalid !== 1'b0 || cpu_rdata !== '0) begin
            errors++;
            $display("[TB] FAIL simul_fft_data: fft_rvalid=%b fft_rdata=%h cpu_rvalid=%b cpu_rdata=%h want 1 6666bbbb 0 0",
                     fft_rvalid, fft_rdata, cpu_rvalid, cpu_rdata);
        end
        toDrive();
    endtask

    task automatic test_reset_mid_burst();
        portView_t o;
        applyStimulus(0, 0, 0, 0, 1, 1, 4'd8, 32'h80, 0);
        toDrive();
        applyStimulus(0, 0, 0, 0, 1, 0, 4'd5, 0, 0);
        toDrive();
        reset = 1'b1;
        applyStimulus(1, 0, 4'd5, 0, 1, 1, 4'd9, 32'h90, 0);
        toSample();
        o = observe();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("[TB] FAIL midburst_reset_outputs: got %h want 0", o);
        end
        toDrive();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        toSample();
        o = observe();
        checks++;
        if (o !== '0) begin
            errors++;
            $display("[TB] FAIL midburst_after_reset: got %h want 0", o);
        end
        toDrive();
        applyStimulus(1, 0, 4'd5, 0, 1, 1, 4'd10, 32'hA0, 1);
        toSample();
        checks++;
        if (cpu_gnt !== 1'b1 || fft_gnt !== 1'b0 || stall_pipe !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midburst_cpu_first: cpu_gnt=%b fft_gnt=%b stall=%b want 1 0 0",
                     cpu_gnt, fft_gnt, stall_pipe);
        end
        toDrive();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        toSample();
        checks++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h5555AAAA) begin
            errors++;
            $display("[TB] FAIL midburst_cpu_data: rvalid=%b rdata=%h want 1 5555aaaa", cpu_rvalid, cpu_rdata);
        end
        toDrive();
    endtask

    task automatic test_random();
        portView_t e, o;
        bit cpuDone, fftDone;
        cpuDone = 1'b1;
        fftDone = 1'b1;
        for (int c = 0; c < 600; c++) begin
            reset = ($urandom_range(0, 79) == 0);
            if (!cpu_req || cpuDone) begin
                cpu_req   = ($urandom_range(0, 2) != 0);
                cpu_we    = $urandom_range(0, 1) == 1;
                cpu_addr  = 4'($urandom_range(0, 15));
                cpu_wdata = $urandom;
            end
            if (!fft_req || fftDone) begin
                fft_req   = ($urandom_range(0, 3) != 0);
                fft_we    = $urandom_range(0, 1) == 1;
                fft_addr  = 4'($urandom_range(0, 15));
                fft_wdata = $urandom;
                fft_last  = ($urandom_range(0, 3) == 0);
            end
            toSample();
            e = modelEval();
            o = observe();
            cpuDone = e.cpuGnt;
            fftDone = e.fftGnt;
            checks++;
            if (o !== e) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: got %h want %h", c, o, e);
            end
            toDrive();
        end
        reset = 1'b0;
        idleCycle();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not end, got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_cpu_store_load();
        test_fft_burst();
        test_burst_max();
        test_starvation();
        test_simultaneous_read();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
